// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared state encoding and default blink timing for the LED path.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam int DEFAULT_ON_CYCLES  = 8;
    localparam int DEFAULT_OFF_CYCLES = 8;

    // Timer only ever holds CYCLES-1, so clog2 of the larger phase suffices.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int max_c;
        max_c = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (max_c > 1) ? $clog2(max_c) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter that parks at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/led_blinker.sv
`default_nettype none
// ============================================================================
// Module      : led_blinker
// Description : Turns a valid/ready blink request of N blinks into an LED
//               pattern of N x (ON high, OFF low) and pulses done at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blinker
    import led_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int               TMR_W    = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             led_q;
    logic             led_d;
    logic             done_q;
    logic             done_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_zero;

    phase_timer #(
        .WIDTH (TMR_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        led_d        = 1'b0;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                // A zero-count request is accepted but produces no activity.
                if (req_valid && (req_count != '0)) begin
                    state_d      = ST_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = ON_LOAD;
                    remaining_d  = req_count - CNT_W'(1);
                    led_d        = 1'b1;
                end
            end

            ST_ON: begin
                led_d = 1'b1;
                if (tmr_zero) begin
                    state_d      = ST_OFF;
                    tmr_load     = 1'b1;
                    tmr_load_val = OFF_LOAD;
                    led_d        = 1'b0;
                end
            end

            ST_OFF: begin
                if (tmr_zero) begin
                    if (remaining_q != '0) begin
                        state_d      = ST_ON;
                        tmr_load     = 1'b1;
                        tmr_load_val = ON_LOAD;
                        remaining_d  = remaining_q - CNT_W'(1);
                        led_d        = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign led       = led_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blinker
// Description : Scoreboard bench for led_blinker (ON=4/OFF=2 and ON=1/OFF=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blinker;

    localparam int CW = 4;

    typedef struct {
        int         cyc;
        logic [3:0] v;   // {led, busy, done, req_ready}
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_a;
    logic [CW-1:0] req_count_a;
    logic          req_valid_b;
    logic [CW-1:0] req_count_b;
    logic          ready_a, led_a, busy_a, done_a;
    logic          ready_b, led_b, busy_b, done_b;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   ndone_a = 0;
    int   ndone_b = 0;
    int   rise_b  = 0;
    logic led_b_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_blinker #(.ON_CYCLES(4), .OFF_CYCLES(2), .CNT_W(CW)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_a),
        .req_count (req_count_a),
        .req_ready (ready_a),
        .led       (led_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    led_blinker #(.ON_CYCLES(1), .OFF_CYCLES(1), .CNT_W(CW)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_b),
        .req_count (req_count_b),
        .req_ready (ready_b),
        .led       (led_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int cy, input logic [3:0] v);
        exp_t e;
        e.cyc = cy;
        e.v   = v;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Expected blink-phase outputs for cycles first..last after the accepting edge at base.
    task automatic exp_blinks(input int d, input int base, input int on, input int off,
                              input int first, input int last);
        for (int k = first; k <= last; k++) begin
            logic l;
            l = (((k - 1) % (on + off)) < on);
            push(d, base + k, {l, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic service(input int d, input logic [3:0] act);
        exp_t e;
        forever begin
            if (d == 0) begin
                if (qa.size() == 0 || qa[0].cyc > cyc) return;
                e = qa.pop_front();
            end else begin
                if (qb.size() == 0 || qb[0].cyc > cyc) return;
                e = qb.pop_front();
            end
            if (e.cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL stale_dut%0d: entry for cycle %0d unchecked at cycle %0d", d, e.cyc, cyc);
            end else begin
                chk($sformatf("dut%0d_cyc%0d {led,busy,done,ready}", d, cyc), {28'd0, act}, {28'd0, e.v});
            end
        end
    endtask

    always @(negedge clk) begin
        service(0, {led_a, busy_a, done_a, ready_a});
        service(1, {led_b, busy_b, done_b, ready_b});
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;
        if (led_b && !led_b_prev) rise_b++;
        led_b_prev = led_b;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int r0;
        rst_n       = 1'b1;
        req_valid_a = 1'b0;
        req_count_a = '0;
        req_valid_b = 1'b0;
        req_count_b = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_a", {28'd0, led_a, busy_a, done_a, ready_a}, 32'h1);
        chk("reset_b", {28'd0, led_b, busy_b, done_b, ready_b}, 32'h1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // ON=4 OFF=2 N=3: led 1-4, 7-10, 13-16; busy 1-18; done at 19
        sync();
        c = cyc;
        req_valid_a = 1'b1;
        req_count_a = 4'd3;
        push(0, c, 4'b0001);
        exp_blinks(0, c, 4, 2, 1, 18);
        push(0, c + 19, 4'b0011);
        push(0, c + 20, 4'b0001);
        sync();
        req_valid_a = 1'b0;
        repeat (21) sync();

        // N=0 accepted: nothing happens
        c = cyc;
        req_valid_a = 1'b1;
        req_count_a = 4'd0;
        for (int k = 0; k <= 5; k++) push(0, c + k, 4'b0001);
        sync();
        req_valid_a = 1'b0;
        repeat (6) sync();

        // N=2 with an N=5 request held pending; second accepted in the done cycle
        c = cyc;
        req_valid_a = 1'b1;
        req_count_a = 4'd2;
        push(0, c, 4'b0001);
        exp_blinks(0, c, 4, 2, 1, 12);
        push(0, c + 13, 4'b0011);
        exp_blinks(0, c + 13, 4, 2, 1, 30);
        push(0, c + 44, 4'b0011);
        push(0, c + 45, 4'b0001);
        sync();
        req_count_a = 4'd5;
        repeat (13) sync();
        req_valid_a = 1'b0;
        repeat (33) sync();

        // N=4 aborted by reset during the second ON phase
        c = cyc;
        req_valid_a = 1'b1;
        req_count_a = 4'd4;
        push(0, c, 4'b0001);
        exp_blinks(0, c, 4, 2, 1, 7);
        sync();
        req_valid_a = 1'b0;
        repeat (7) sync();
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_a", {28'd0, led_a, busy_a, done_a, ready_a}, 32'h1);
        push(0, c + 8, 4'b0001);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 9; k <= 20; k++) push(0, c + k, 4'b0001);
        repeat (13) sync();

        // ON=1 OFF=1 N=15: alternating for 30 cycles, done at 31
        c  = cyc;
        r0 = rise_b;
        req_valid_b = 1'b1;
        req_count_b = 4'd15;
        push(1, c, 4'b0001);
        exp_blinks(1, c, 1, 1, 1, 30);
        push(1, c + 31, 4'b0011);
        push(1, c + 32, 4'b0001);
        sync();
        req_valid_b = 1'b0;
        repeat (33) sync();
        chk("rising_edges_b", rise_b - r0, 32'd15);

        // Back-to-back N=1 with valid held: period ON + OFF + 1
        c = cyc;
        req_valid_a = 1'b1;
        req_count_a = 4'd1;
        push(0, c, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            exp_blinks(0, c + 7 * i, 4, 2, 1, 6);
            push(0, c + 7 * i + 7, 4'b0011);
        end
        push(0, c + 22, 4'b0001);
        sync();
        repeat (14) sync();
        req_valid_a = 1'b0;
        repeat (10) sync();

        chk("pending_a", qa.size(), 32'd0);
        chk("pending_b", qb.size(), 32'd0);
        chk("done_count_a", ndone_a, 32'd6);
        chk("done_count_b", ndone_b, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
